hazard_forward_unit: RTL

Parametrised forwarding and hazard controller for the pipelined TSC datapath, replacing the fixed 2-source forwarding logic. Evaluates the ID-stage source registers against EX, MEM and WB producers. Registers the per-source bypass selects so they align with the consumer in EX. Also owns load-use stalling, control-redirect flushing, halt drain sequencing and a saturating stall counter.

---
 rtl/hazard_forward_unit_pkg.sv | 39 +++
 rtl/fwd_match_lane.sv | 49 ++++
 rtl/hazard_forward_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/hazard_forward_unit_pkg.sv
// Shared encodings for the TSC forwarding/hazard controller: bypass selects,
// sequencer states and the pipeline-control bundle driven toward the latches.
package hazard_forward_unit_pkg;

    typedef enum logic [1:0] {
        FWD_RF     = 2'd0,
        FWD_MEMWB  = 2'd1,
        FWD_EXMEM  = 2'd2,
        FWD_WBHOLD = 2'd3
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } hz_state_e;

    // Wide enough for the 1..7 range of both stall and drain lengths.
    localparam int SEQ_CNT_W = 3;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_PASS  = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0};
    localparam pipe_ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b1};
    localparam pipe_ctrl_t CTRL_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1};
    localparam pipe_ctrl_t CTRL_HOLD  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b0};

    // Sequencer counters run from length-1 down to 0.
    function automatic logic [SEQ_CNT_W-1:0] seq_preload(input int cycles);
        return SEQ_CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/fwd_match_lane.sv
// One source operand's producer comparison: picks the next bypass select
// (EX > MEM > WB) and flags a load-use hazard against the EX-stage load.
module fwd_match_lane
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_ADDR_W         = 2,
    parameter int RF_WRITE_THROUGH   = 1,
    parameter int ZERO_REG_HARDWIRED = 0
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  used,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  ex_reg_write,
    input  logic                  mem_reg_write,
    input  logic                  wb_reg_write,
    input  logic                  ex_mem_read,
    output logic [1:0]            next_sel,
    output logic                  load_use
);

    logic rs_live;
    logic hit_ex;
    logic hit_mem;
    logic hit_wb;

    // A hardwired zero register is never produced, so it can never be bypassed.
    assign rs_live = used && !((ZERO_REG_HARDWIRED != 0) && (rs == '0));

    assign hit_ex  = rs_live && ex_reg_write  && (ex_rd  == rs);
    assign hit_mem = rs_live && mem_reg_write && (mem_rd == rs);
    assign hit_wb  = rs_live && wb_reg_write  && (wb_rd  == rs);

    assign load_use = ex_mem_read && hit_ex;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        next_sel = FWD_RF;
        if (hit_ex) begin
            next_sel = FWD_EXMEM;
        end else if (hit_mem) begin
            next_sel = FWD_MEMWB;
        end else if (hit_wb && (RF_WRITE_THROUGH == 0)) begin
            next_sel = FWD_WBHOLD;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding and hazard controller for the pipelined TSC datapath: registered
// bypass selects, load-use stalls, redirect flushes, halt drain, stall counter.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_ADDR_W         = 2,
    parameter int NUM_SRC            = 2,
    parameter int LOAD_STALL_CYCLES  = 1,
    parameter int DRAIN_CYCLES       = 3,
    parameter int RF_WRITE_THROUGH   = 1,
    parameter int ZERO_REG_HARDWIRED = 0,
    parameter int CNT_W              = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]            id_rs_used,
    input  logic                          id_halt,
    input  logic [REG_ADDR_W-1:0]         ex_rd,
    input  logic [REG_ADDR_W-1:0]         mem_rd,
    input  logic [REG_ADDR_W-1:0]         wb_rd,
    input  logic                          ex_reg_write,
    input  logic                          mem_reg_write,
    input  logic                          wb_reg_write,
    input  logic                          ex_mem_read,
    input  logic                          ex_redirect,
    output logic [NUM_SRC*2-1:0]          fwd_sel,
    output logic                          pc_write,
    output logic                          ifid_write,
    output logic                          ifid_flush,
    output logic                          idex_bubble,
    output logic                          halted,
    output logic [CNT_W-1:0]              stall_count
);

    localparam logic [SEQ_CNT_W-1:0] LDSTALL_LOAD = seq_preload(LOAD_STALL_CYCLES);
    localparam logic [SEQ_CNT_W-1:0] DRAIN_LOAD   = seq_preload(DRAIN_CYCLES);

    hz_state_e              state;
    logic [SEQ_CNT_W-1:0]   seq_cnt;
    logic [NUM_SRC*2-1:0]   next_fwd;
    logic [NUM_SRC-1:0]     lane_load_use;
    logic                   load_use;
    pipe_ctrl_t             ctrl;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
        fwd_match_lane #(
            .REG_ADDR_W         (REG_ADDR_W),
            .RF_WRITE_THROUGH   (RF_WRITE_THROUGH),
            .ZERO_REG_HARDWIRED (ZERO_REG_HARDWIRED)
        ) u_lane (
            .rs            (id_rs[i*REG_ADDR_W +: REG_ADDR_W]),
            .used          (id_rs_used[i]),
            .ex_rd         (ex_rd),
            .mem_rd        (mem_rd),
            .wb_rd         (wb_rd),
            .ex_reg_write  (ex_reg_write),
            .mem_reg_write (mem_reg_write),
            .wb_reg_write  (wb_reg_write),
            .ex_mem_read   (ex_mem_read),
            .next_sel      (next_fwd[i*2 +: 2]),
            .load_use      (lane_load_use[i])
        );
    end

    assign load_use = |lane_load_use;

    // Redirect wins over load-use and halt: the instruction in ID is wrong-path.
    always_comb begin
        ctrl = CTRL_PASS;
        if (!reset) begin
            case (state)
                RUN: begin
                    if (ex_redirect) begin
                        ctrl = CTRL_FLUSH;
                    end else if (load_use) begin
                        ctrl = CTRL_STALL;
                    end else if (id_halt) begin
                        ctrl = CTRL_HOLD;
                    end
                end
                LDSTALL: ctrl = ex_redirect ? CTRL_FLUSH : CTRL_STALL;
                DRAIN:   ctrl = CTRL_STALL;
                HALTED:  ctrl = CTRL_STALL;
                default: ctrl = CTRL_PASS;
            endcase
        end
    end

    assign pc_write    = ctrl.pc_write;
    assign ifid_write  = ctrl.ifid_write;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_bubble = ctrl.idex_bubble;
    assign halted      = (state == HALTED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state is updated with <= only, so every register samples pre-edge values.
            state   <= RUN;
            seq_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (!ex_redirect) begin
                        if (load_use) begin
                            seq_cnt <= LDSTALL_LOAD;
                            state   <= (LOAD_STALL_CYCLES > 1) ? LDSTALL : RUN;
                        end else if (id_halt) begin
                            seq_cnt <= DRAIN_LOAD;
                            state   <= DRAIN;
                        end
                    end
                end
                LDSTALL: begin
                    // The RUN cycle that detected the hazard was the first bubble.
                    if (ex_redirect || (seq_cnt <= SEQ_CNT_W'(1))) begin
                        seq_cnt <= '0;
                        state   <= RUN;
                    end else begin
                        seq_cnt <= seq_cnt - 1'b1;
                    end
                end
                DRAIN: begin
                    if (seq_cnt == '0) begin
                        state <= HALTED;
                    end else begin
                        seq_cnt <= seq_cnt - 1'b1;
                    end
                end
                HALTED:  state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end

    // Selects are captured at the ID->EX edge; a bubble in EX forwards nothing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_sel     <= '0;
            stall_count <= '0;
        end else begin
            fwd_sel <= ctrl.idex_bubble ? '0 : next_fwd;
            if (ctrl.idex_bubble && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule
